// File: rtl/fifo_drain_sched.sv
// Round-robin read scheduler. It drains a bank of synchronous FIFOs into one
// valid/ready stream and tags each word with the channel it came from.
// Each grant moves up to BURST_MAX words. Every word takes three cycles:
// RD strobes the FIFO, CAP captures the registered FIFO output, and OUT
// holds the word until the downstream handshake.
module fifo_drain_sched #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_W       = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            ch_en,
    input  logic [NUM_CH-1:0]            fifo_empty,
    output logic [NUM_CH-1:0]            fifo_rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] fifo_rd_data,
    output logic [DATA_WIDTH-1:0]        out_data,
    output logic [CH_W-1:0]              out_ch,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         busy
);

    typedef enum logic [1:0] {StIdle, StRd, StCap, StOut} state_t;

    state_t                state_q, state_d;
    logic [CH_W-1:0]       grant_q, grant_d;
    logic [CH_W-1:0]       last_q, last_d;
    logic [7:0]            burst_q, burst_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [CH_W-1:0]       och_q, och_d;
    logic                  valid_q, valid_d;

    logic [NUM_CH-1:0]     eligible;
    logic                  grant_ok;
    logic                  rr_found;
    logic [CH_W-1:0]       rr_ch;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [8:0]            burst_inc;

    assign eligible  = ch_en & ~fifo_empty;
    assign grant_ok  = eligible[grant_q];
    assign burst_inc = {1'b0, burst_q} + 9'd1;
    assign rd_word   = DATA_WIDTH'(fifo_rd_data >> (32'(grant_q) * DATA_WIDTH));

    // Search from last_ch+1 upward. The index wraps at NUM_CH and not at 2^CH_W.
    always_comb begin
        int unsigned       idx;
        logic [NUM_CH-1:0] shifted;
        rr_found = 1'b0;
        rr_ch    = '0;
        idx      = 0;
        shifted  = '0;
        for (int unsigned off = 1; off <= NUM_CH; off++) begin
            idx     = (32'(last_q) + off) % NUM_CH;
            shifted = eligible >> idx;
            if (!rr_found && shifted[0]) begin
                rr_found = 1'b1;
                rr_ch    = CH_W'(idx);
            end
        end
    end

    // Strobe the granted FIFO only while it still has data and is enabled.
    always_comb begin
        fifo_rd_en = '0;
        if (state_q == StRd && grant_ok) begin
            fifo_rd_en = NUM_CH'(1) << grant_q;
        end
    end

    // Next-state logic for the grant, burst count and output registers.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        burst_d = burst_q;
        data_d  = data_q;
        och_d   = och_q;
        valid_d = valid_q;
        unique case (state_q)
            StIdle: begin
                if (rr_found) begin
                    grant_d = rr_ch;
                    burst_d = '0;
                    state_d = StRd;
                end
            end
            StRd: begin
                if (grant_ok) begin
                    state_d = StCap;
                end else begin
                    last_d  = grant_q;
                    state_d = StIdle;
                end
            end
            StCap: begin
                data_d  = rd_word;
                och_d   = grant_q;
                valid_d = 1'b1;
                state_d = StOut;
            end
            StOut: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    burst_d = burst_inc[7:0];
                    if (32'(burst_inc) < BURST_MAX && grant_ok) begin
                        state_d = StRd;
                    end else begin
                        last_d  = grant_q;
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State registers with synchronous reset. Reset discards any captured word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= CH_W'(NUM_CH - 1);
            burst_q <= '0;
            data_q  <= '0;
            och_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            burst_q <= burst_d;
            data_q  <= data_d;
            och_q   <= och_d;
            valid_q <= valid_d;
        end
    end

    assign out_data  = data_q;
    assign out_ch    = och_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: doc/fifo_drain_sched.md
Name: fifo_drain_sched

Overview:
- Round-robin read scheduler that drains NUM_CH synchronous FIFOs, all on one clock, into a single valid/ready output stream.
- Sits on the read side of a bank of per-channel FIFOs. It owns every fifo_rd_en, captures the registered FIFO read data, and tags each word with its source channel.
- Bursts of up to BURST_MAX words per grant keep a busy channel from starving the others.

Parameters:
- NUM_CH, 4, number of FIFO channels served (2..16)
- CH_W, 2, channel index width, log2(NUM_CH)
- DATA_WIDTH, 8, FIFO word width
- BURST_MAX, 4, maximum words drained per grant (1..255)

Ports:
- clk  input  1  single clock; all FIFO read sides run on it
- rst  input  1  synchronous reset, active-high
- ch_en  input  NUM_CH  per-channel enable mask
- fifo_empty  input  NUM_CH  per-channel FIFO empty flag
- fifo_rd_en  output  NUM_CH  per-channel read strobe, at most one bit high per cycle
- fifo_rd_data  input  NUM_CH*DATA_WIDTH  concatenated FIFO outputs, ch0 in LSBs; valid the cycle after its rd_en
- out_data  output  DATA_WIDTH  drained word
- out_ch  output  CH_W  source channel of out_data
- out_valid  output  1  out_data/out_ch valid
- out_ready  input  1  downstream accept
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) gives:
  - state=IDLE, fifo_rd_en=0, out_valid=0, out_data=0, out_ch=0, busy=0, burst_cnt=0
  - last_ch=NUM_CH-1, so channel 0 has first priority.
- Eligibility: channel i is eligible when ch_en[i]=1 and fifo_empty[i]=0.
- IDLE:
  - Search channels last_ch+1, last_ch+2, ... modulo NUM_CH.
  - First eligible channel found becomes grant_ch; burst_cnt=0; go to RD.
  - If none is eligible, stay in IDLE.
- RD (one cycle):
  - fifo_rd_en[grant_ch]=1 only if grant_ch is still eligible in this cycle; then go to CAP.
  - If grant_ch is no longer eligible: no strobe, last_ch=grant_ch, go to IDLE.
- CAP (one cycle):
  - out_data <= fifo_rd_data slice for grant_ch.
  - out_ch <= grant_ch; out_valid <= 1; go to OUT.
- OUT:
  - Hold out_data, out_ch and out_valid stable until out_valid&&out_ready.
  - On that handshake: out_valid <= 0 and burst_cnt <= burst_cnt+1.
  - If burst_cnt+1 < BURST_MAX and grant_ch is eligible in the handshake cycle, go to RD (burst continues).
  - Otherwise last_ch <= grant_ch and go to IDLE (grant ends).
- Throughput: 3 cycles per word with out_ready held high. First rd_en comes 1 cycle after eligibility is seen in IDLE.
- Ordering: words leave in FIFO order within a channel. No word is dropped or duplicated.
- fifo_rd_en is never asserted on an empty or disabled channel.
- ch_en deasserted mid-burst: any word already strobed still completes CAP/OUT, then the burst ends.
- Simultaneous eligibility: the round-robin order from last_ch+1 decides; ties are impossible.
- NUM_CH not a power of two: indices wrap at NUM_CH, never at 2^CH_W.
- Reset mid-operation: outputs return to reset values on the next edge. A word captured but not yet handshaken is discarded. A word strobed in RD is consumed from the FIFO and lost.

Test Plan:
- Reset, then ch1 non-empty with 3 words A1,A2,A3, all ch_en=1, out_ready=1 -> fifo_rd_en=4'b0010 on cycles 2,5,8 after reset release; out_ch=1 with A1,A2,A3; burst ends when ch1 goes empty; busy=0 afterwards.
- ch0 and ch2 each hold 6 words, BURST_MAX=4 -> output order: ch0 x4, ch2 x4, ch0 x2, ch2 x2.
- out_ready held low for 5 cycles during OUT -> out_data/out_ch/out_valid stable for all 5 cycles; no fifo_rd_en pulse; the next read starts only after the handshake.
- ch_en[3] cleared during OUT of the 2nd word of a ch3 burst -> 2nd word still delivered; no further ch3 reads; grant passes to the next eligible channel.
- rst asserted for 1 cycle in OUT -> next cycle out_valid=0, busy=0; after release ch0 is granted first if eligible.
- NUM_CH=3, all channels eligible continuously, BURST_MAX=1 -> grant sequence 0,1,2,0,1,2…; fifo_rd_en is never multi-hot and never hits an empty channel.
